// File: rtl/johnson_pkg.sv
// johnson_pkg: shared FSM state and step-class encodings for the Johnson monitor
package johnson_pkg;

    localparam logic [1:0] ACQUIRE = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] FAULT   = 2'd2;

    localparam logic [1:0] STEP_ADVANCE = 2'd0;
    localparam logic [1:0] STEP_HOLD    = 2'd1;
    localparam logic [1:0] STEP_BAD     = 2'd2;

endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: combinational Johnson code legality check and state index decode
module johnson_decode #(
    parameter int N  = 7,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  Q_in,
    output logic          legal,
    output logic [IW-1:0] index
);

    localparam int PW = $clog2(N + 1);

    logic [PW-1:0] ones;
    logic [PW-1:0] edges;

    // popcount gives the position; a legal code has at most one 0/1 boundary
    always_comb begin
        ones  = '0;
        edges = '0;
        for (int i = 0; i < N; i++) ones = ones + PW'(Q_in[i]);
        for (int i = 0; i < N - 1; i++) edges = edges + PW'(Q_in[i] ^ Q_in[i+1]);
        legal = edges <= PW'(1);
        index = Q_in[N-1] ? IW'(ones) : (ones == '0 ? '0 : IW'(2 * N) - IW'(ones));
    end

endmodule

// File: rtl/johnson_monitor.sv
// johnson_monitor: decodes a Johnson-coded bus, checks its stepping and counts rotations
module johnson_monitor
    import johnson_pkg::*;
#(
    parameter int N  = 7,
    parameter int CW = 8,
    localparam int IW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic [N-1:0]  Q_in,
    output logic [IW-1:0] idx,
    output logic          code_ok,
    output logic          locked,
    output logic          step_err,
    output logic          fault,
    output logic [CW-1:0] cycles
);

    logic          legal;
    logic [IW-1:0] d;
    logic [IW-1:0] idx_next;
    logic [1:0]    step;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          err_nxt;
    logic          wrap;

    johnson_decode #(.N(N), .IW(IW)) u_decode (
        .Q_in  (Q_in),
        .legal (legal),
        .index (d)
    );

    // classify the incoming sample against the current index
    always_comb begin
        idx_next  = (idx == IW'(2 * N - 1)) ? '0 : idx + 1'b1;
        step      = !legal ? STEP_BAD : d == idx_next ? STEP_ADVANCE : d == idx ? STEP_HOLD : STEP_BAD;
        wrap      = (step == STEP_ADVANCE) && (idx == IW'(2 * N - 1));
        err_nxt   = (state == ACQUIRE) ? !legal : (step == STEP_BAD);
        state_nxt = (state == ACQUIRE) ? (legal ? TRACK : FAULT) :
                    (state == TRACK && step == STEP_BAD) ? FAULT : state;
    end

    // FAULT is absorbing; only the asynchronous clear leaves it
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= ACQUIRE;
            idx      <= '0;
            code_ok  <= 1'b0;
            step_err <= 1'b0;
            cycles   <= '0;
        end else begin
            state    <= state_nxt;
            code_ok  <= legal;
            step_err <= err_nxt;
            if (legal) idx <= d;
            if (state == TRACK && wrap && cycles != '1) cycles <= cycles + 1'b1;
        end
    end

    assign locked = (state == TRACK);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_johnson_monitor.sv
// tb_johnson_monitor: directed checks of decode, tracking, fault and saturation behaviour
module tb_johnson_monitor;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [3:0] q4 = '0;
    logic [6:0] q7 = '0;

    logic [2:0] idx4, idxs;
    logic [3:0] idx7;
    logic       ok4, lk4, err4, flt4;
    logic       ok7, lk7, err7, flt7;
    logic       oks, lks, errs, flts;
    logic [7:0] cyc4, cyc7;
    logic [1:0] cycs;

    int n_chk = 0;
    int n_fail = 0;

    johnson_monitor #(.N(4), .CW(8)) u4 (
        .clk(clk), .clear_n(clear_n), .Q_in(q4), .idx(idx4), .code_ok(ok4),
        .locked(lk4), .step_err(err4), .fault(flt4), .cycles(cyc4)
    );

    johnson_monitor #(.N(7), .CW(8)) u7 (
        .clk(clk), .clear_n(clear_n), .Q_in(q7), .idx(idx7), .code_ok(ok7),
        .locked(lk7), .step_err(err7), .fault(flt7), .cycles(cyc7)
    );

    johnson_monitor #(.N(4), .CW(2)) us (
        .clk(clk), .clear_n(clear_n), .Q_in(q4), .idx(idxs), .code_ok(oks),
        .locked(lks), .step_err(errs), .fault(flts), .cycles(cycs)
    );

    initial forever #5 clk = ~clk;

    function automatic int jc(input int n, input int k);
        return (k <= n) ? (((1 << k) - 1) << (n - k)) : ((1 << (2 * n - k)) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        #17;
        chk("rst_idx", idx4, 0);
        chk("rst_ok", ok4, 0);
        chk("rst_locked", lk4, 0);
        chk("rst_err", err4, 0);
        chk("rst_fault", flt4, 0);
        chk("rst_cycles", cyc4, 0);
        chk("rst_idx7", idx7, 0);
        chk("rst_cycles_sat", cycs, 0);
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            q4 = 4'(jc(4, i % 8));
            tick();
            chk("run_idx", idx4, i % 8);
            chk("run_ok", ok4, 1);
            chk("run_locked", lk4, 1);
            chk("run_fault", flt4, 0);
            chk("run_err", err4, 0);
            chk("run_cycles", cyc4, i / 8);
            chk("sat_idx", idxs, i % 8);
            chk("sat_ok", oks, 1);
            chk("sat_locked", lks, 1);
            chk("sat_err", errs, 0);
            chk("sat_fault", flts, 0);
            chk("sat_cycles", cycs, (i / 8 > 3) ? 3 : i / 8);
        end
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            q4 = 4'b0000;
            tick();
            chk("hold_idx", idx4, 0);
            chk("hold_locked", lk4, 1);
            chk("hold_err", err4, 0);
        end
        for (int i = 1; i < 19; i++) begin
            q4 = 4'(jc(4, i % 8));
            tick();
            chk("adv_idx", idx4, i % 8);
        end
        chk("pre_bad_cycles", cyc4, 2);
        q4 = 4'b1111;
        tick();
        chk("bad_err", err4, 1);
        chk("bad_fault", flt4, 1);
        chk("bad_locked", lk4, 0);
        chk("bad_idx", idx4, 4);
        chk("bad_ok", ok4, 1);
        chk("bad_cycles", cyc4, 2);
        tick();
        chk("flt_hold_err", err4, 0);
        chk("flt_hold_fault", flt4, 1);
        q4 = 4'b0111;
        tick();
        chk("flt_idx5", idx4, 5);
        q4 = 4'b0011;
        tick();
        q4 = 4'b0001;
        tick();
        chk("flt_idx7", idx4, 7);
        q4 = 4'b0000;
        tick();
        chk("flt_wrap_idx", idx4, 0);
        chk("flt_wrap_cycles", cyc4, 2);
        chk("flt_wrap_err", err4, 0);
        q4 = 4'b0110;
        tick();
        chk("flt_ill_ok", ok4, 0);
        chk("flt_ill_idx", idx4, 0);
        chk("flt_ill_err", err4, 1);
        chk("flt_ill_fault", flt4, 1);
        @(negedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        chk("mid_rst_idx", idx4, 0);
        chk("mid_rst_ok", ok4, 0);
        chk("mid_rst_locked", lk4, 0);
        chk("mid_rst_err", err4, 0);
        chk("mid_rst_fault", flt4, 0);
        chk("mid_rst_cycles", cyc4, 0);
        @(negedge clk);
        clear_n = 1'b1;
        q4 = 4'b1110;
        tick();
        chk("reacq_idx", idx4, 3);
        chk("reacq_locked", lk4, 1);
        q4 = 4'b1111;
        tick();
        chk("reacq_adv_idx", idx4, 4);
        chk("reacq_adv_err", err4, 0);
        chk("reacq_adv_fault", flt4, 0);
        reset_pulse();
        q4 = 4'b1000;
        tick();
        chk("ill_pre_idx", idx4, 1);
        chk("ill_pre_locked", lk4, 1);
        q4 = 4'b0100;
        tick();
        chk("ill_ok", ok4, 0);
        chk("ill_idx", idx4, 1);
        chk("ill_fault", flt4, 1);
        chk("ill_err", err4, 1);
        chk("ill_locked", lk4, 0);
        reset_pulse();
        tick();
        chk("acq_ill_fault", flt4, 1);
        chk("acq_ill_ok", ok4, 0);
        chk("acq_ill_idx", idx4, 0);
        chk("acq_ill_err", err4, 1);
        reset_pulse();
        for (int k = 0; k < 14; k++) begin
            q7 = 7'(jc(7, k));
            tick();
            chk("sweep_idx", idx7, k);
            chk("sweep_ok", ok7, 1);
            chk("sweep_locked", lk7, 1);
            chk("sweep_err", err7, 0);
            chk("sweep_fault", flt7, 0);
        end
        q7 = 7'b0000000;
        tick();
        chk("n7_wrap_idx", idx7, 0);
        chk("n7_wrap_cycles", cyc7, 1);
        q7 = 7'b1110000;
        tick();
        chk("n7_idx3", idx7, 3);
        chk("n7_jump_err", err7, 1);
        q7 = 7'b0000111;
        tick();
        chk("n7_idx11", idx7, 11);
        chk("n7_ok11", ok7, 1);
        q7 = 7'b1010000;
        tick();
        chk("n7_ill_ok", ok7, 0);
        chk("n7_ill_idx", idx7, 11);
        chk("n7_ill_fault", flt7, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_monitor.md
# johnson_monitor

Receive-side companion to `johnson_counter`. It samples an N-bit Johnson code, decodes it to a binary state index (0..2N-1), and checks that every code is legal and every step follows the counter sequence. It counts completed rotations and latches a sticky fault on any violation. It sits beside a `johnson_counter` instance, or downstream of any Johnson-coded bus in the same clock domain, as a decoder and integrity checker.

## Interface
- `N`, 7, Johnson code width; the sequence has 2N states.
- `CW`, 8, width of the rotation counter.
- Derived `IW` = $clog2(2N), width of the state index.

Ports:
- `clk`  in  1  clock, rising-edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `Q_in`  in  N  Johnson code, synchronous to `clk`.
- `idx`  out  IW  decoded index of the last legal sample.
- `code_ok`  out  1  last sample was a legal Johnson code.
- `locked`  out  1  FSM is in TRACK.
- `step_err`  out  1  one-cycle pulse on an illegal code or bad step.
- `fault`  out  1  sticky error flag.
- `cycles`  out  CW  completed rotations, saturating.

## Operation
- Canonical sequence, MSB first: state k in 0..N is k leading ones then zeros. State k in N+1..2N-1 is (k-N) leading zeros then ones.
  - N=4 sequence: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then back to 0000.
- A code is legal iff at most one adjacent bit pair Q[i] != Q[i+1]. There are exactly 2N legal codes.
- Decode, with p = popcount:
  - if Q[N-1] = 1: idx = p;
  - else if p = 0: idx = 0;
  - else: idx = 2N - p.
- Step classification: d = decode(`Q_in`), r = current `idx`.
  - ADVANCE if d = (r+1) mod 2N.
  - HOLD if d = r.
  - otherwise BAD.
- FSM states:
  - ACQUIRE (reset state):
    - legal sample -> TRACK; `idx` loads d; no step check.
    - illegal sample -> FAULT.
  - TRACK:
    - ADVANCE or HOLD -> stay; `idx` loads d.
    - ADVANCE from 2N-1 to 0 increments `cycles`; saturates at all ones.
    - illegal code or BAD -> FAULT.
  - FAULT:
    - `fault` = 1, `locked` = 0, `cycles` frozen.
    - decoding continues: `code_ok` is updated, and `idx` loads every legal sample.
    - only `clear_n` exits.
- Illegal sample in any state: `code_ok` = 0 and `idx` holds its previous value.
- `step_err` pulses on the cycle the FSM enters FAULT, and on each further illegal or BAD sample while in FAULT.

## Timing
- All outputs registered. `Q_in` sampled at edge t is reflected on every output after edge t (latency 1).
- Reset (`clear_n` low, asynchronous, at any time including mid-rotation):
  - FSM -> ACQUIRE.
  - `idx` = 0, `code_ok` = 0, `locked` = 0, `step_err` = 0, `fault` = 0, `cycles` = 0.
- Release is sampled at the first rising edge after `clear_n` rises.
- `locked` rises on the edge that takes the first legal sample; that same edge loads `idx`.
- Wrap boundary: the `cycles` increment and the `idx` = 0 update occur on the same edge.
- Simultaneous wrap and saturation: `cycles` stays at 2^CW-1, and no error is raised.
- HOLD is unlimited, so a counter that is held in reset (0 repeated) is not an error.

## Structure
- `johnson_pkg` holds:
  - FSM state encoding: ACQUIRE = 2'd0, TRACK = 2'd1, FAULT = 2'd2;
  - the step class constants.
- Sub-module `johnson_decode`: purely combinational, `Q_in` -> {legal, index}, parameterised on N. It is instantiated once.
- Top level `johnson_monitor` holds the FSM, the `idx` register, step compare, and the saturating counter.

## Test plan
- Driven by a `johnson_counter` instance (N=4):
  - Stimulus: reset low for 15 ns, release, run 20 clocks.
  - Response:
    - `locked` = 1 one edge after the first sample;
    - `idx` follows 0,1,…,7,0;
    - `cycles` = 2 after 16 advances;
    - `fault` stays 0.
- Decode sweep (N=7): apply all 14 legal codes.
  - Required: `idx` equals the sequence position, e.g. 1110000 -> 3 and 0000111 -> 11.
  - 1010000 -> `code_ok` = 0.
- Bad step in TRACK (N=4): 1100 (2), then 1111 (4).
  - Required: `step_err` pulses once, `fault` = 1, `locked` = 0, `idx` = 4.
  - `cycles` does not change afterwards.
- Illegal code in TRACK:
  - Stimulus: 1000, then 0100.
  - Required: `code_ok` = 0, `idx` stays 1, `fault` = 1.
- Saturation (N=4, CW=2): run 5 full rotations.
  - Required: `cycles` reaches 3 and holds; no fault.
- Reset mid-operation:
  - Stimulus: assert `clear_n` between clock edges while in FAULT with `cycles` = 2.
  - Required: all outputs reach their reset values immediately.
  - After release: re-acquires and tracks normally.
